// File: rtl/vga_axil_master.sv
// -----------------------------------------------------------------------------
// vga_axil_master
//   AXI-Lite manager for the VGA subsystem. It accepts one native word request
//   at a time, issues the matching AXI-Lite read or write, and returns read
//   data and an error flag on the native response channel. Only one
//   transaction is outstanding, and every AXI output comes from a register.
//
//   The native address is a 29-bit word address. The AXI address is that word
//   address shifted left by three ({req_addr_i, 3'b000}), so bits [2:0] are
//   always zero.
//
// Parameters
//   ERR_CNT_WIDTH  width of the saturating non-OKAY response counter
//
// Optional feature
//   Define VGA_AXIL_MASTER_ERR_CNT_EN to add err_cnt_o. The counter adds one
//   per B/R handshake whose response is not OKAY, sticks at all-ones, and is
//   cleared only by reset. Without the macro, neither the port nor the counter
//   exists.
//
// Ports
//   clk_i, arst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      native request handshake
//   req_we_i, req_addr_i           1 = write; 29-bit word address
//   req_wdata_i, req_wstrb_i       write data and byte strobes
//   rsp_valid_o / rsp_ready_i      native response handshake
//   rsp_rdata_o, rsp_err_o         read data (0 for writes); 1 = not OKAY
//   m_aw*, m_w*, m_b*              AXI-Lite write address/data/response
//   m_ar*, m_r*                    AXI-Lite read address/data
//   err_cnt_o                      non-OKAY count (optional)
// -----------------------------------------------------------------------------
module vga_axil_master #(
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [28:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] m_awaddr_o,
  output logic        m_awvalid_o,
  input  logic        m_awready_i,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  output logic        m_wvalid_o,
  input  logic        m_wready_i,
  input  logic [1:0]  m_bresp_i,
  input  logic        m_bvalid_i,
  output logic        m_bready_o,
  output logic [31:0] m_araddr_o,
  output logic        m_arvalid_o,
  input  logic        m_arready_i,
  input  logic [31:0] m_rdata_i,
  input  logic [1:0]  m_rresp_i,
  input  logic        m_rvalid_i,
  output logic        m_rready_o
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
`endif
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_e;

  state_e state;
  logic   aw_done;
  logic   w_done;
  logic   aw_fire;
  logic   w_fire;

  // The counter holds at all-ones instead of wrapping to zero.
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign aw_fire = m_awvalid_o & m_awready_i;
  assign w_fire  = m_wvalid_o & m_wready_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      m_awaddr_o  <= '0;
      m_awvalid_o <= 1'b0;
      m_wdata_o   <= '0;
      m_wstrb_o   <= '0;
      m_wvalid_o  <= 1'b0;
      m_bready_o  <= 1'b0;
      m_araddr_o  <= '0;
      m_arvalid_o <= 1'b0;
      m_rready_o  <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        // req_ready_o is high only in this state, so req_valid_i alone
        // completes the handshake.
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            if (req_we_i) begin
              m_awaddr_o  <= {req_addr_i, 3'b000};
              m_wdata_o   <= req_wdata_i;
              m_wstrb_o   <= req_wstrb_i;
              m_awvalid_o <= 1'b1;
              m_wvalid_o  <= 1'b1;
              state       <= WR;
            end else begin
              m_araddr_o  <= {req_addr_i, 3'b000};
              m_arvalid_o <= 1'b1;
              state       <= RD_ADDR;
            end
          end
        end

        // AW and W finish independently and in either order. Each valid
        // drops on its own handshake.
        WR: begin
          if (aw_fire) m_awvalid_o <= 1'b0;
          if (w_fire)  m_wvalid_o  <= 1'b0;
          aw_done <= aw_done | aw_fire;
          w_done  <= w_done | w_fire;
          if ((aw_done | aw_fire) && (w_done | w_fire)) begin
            m_bready_o <= 1'b1;
            state      <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_bvalid_i) begin
            m_bready_o  <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= (m_bresp_i != RESP_OKAY);
            rsp_valid_o <= 1'b1;
            state       <= RSP;
          end
        end

        RD_ADDR: begin
          if (m_arready_i) begin
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b1;
            state       <= RD_DATA;
          end
        end

        // Read data is forwarded even when the response is an error.
        RD_DATA: begin
          if (m_rvalid_i) begin
            m_rready_o  <= 1'b0;
            rsp_rdata_o <= m_rdata_i;
            rsp_err_o   <= (m_rresp_i != RESP_OKAY);
            rsp_valid_o <= 1'b1;
            state       <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
  // The wait-state qualifiers mean only real B/R handshakes are counted.
  // Stray valids outside WR_RESP/RD_DATA never advance the counter.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      err_cnt_o <= '0;
    end else if ((state == WR_RESP && m_bvalid_i && m_bresp_i != RESP_OKAY) ||
                 (state == RD_DATA && m_rvalid_i && m_rresp_i != RESP_OKAY)) begin
      err_cnt_o <= sat_inc(err_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_vga_axil_master.sv
// -----------------------------------------------------------------------------
// tb_vga_axil_master
//   Self-checking bench for vga_axil_master. The bench plays the AXI-Lite
//   subordinate, with randomized ready and response delays, and plays the
//   native requester.
//
//   Expected values come from the rules of the interface:
//     - AXI address = word address * 8
//     - error flag  = response != OKAY
//     - read data   = R data for reads, 0 for writes
//     - latency     = 3 cycles plus the slowest address-phase delay plus the
//                     response delay
//
//   With VGA_AXIL_MASTER_ERR_CNT_EN defined, the bench also checks the
//   saturating error counter (width 2).
// -----------------------------------------------------------------------------
module tb_vga_axil_master;

  localparam int BOUND = 50;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        req_valid, req_ready, req_we;
  logic [28:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
  logic [1:0]  err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          viol;
    logic        tmo;
  } obs_t;

  vga_axil_master #(.ERR_CNT_WIDTH(2)) dut (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .m_awaddr_o  (m_awaddr),
    .m_awvalid_o (m_awvalid),
    .m_awready_i (m_awready),
    .m_wdata_o   (m_wdata),
    .m_wstrb_o   (m_wstrb),
    .m_wvalid_o  (m_wvalid),
    .m_wready_i  (m_wready),
    .m_bresp_i   (m_bresp),
    .m_bvalid_i  (m_bvalid),
    .m_bready_o  (m_bready),
    .m_araddr_o  (m_araddr),
    .m_arvalid_o (m_arvalid),
    .m_arready_i (m_arready),
    .m_rdata_i   (m_rdata),
    .m_rresp_i   (m_rresp),
    .m_rvalid_i  (m_rvalid),
    .m_rready_o  (m_rready)
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic logic [31:0] exp_addr(input logic [28:0] a);
    return 32'(a) * 32'd8;
  endfunction

  function automatic int exp_lat(input logic we, input int a_dly, input int w_dly, input int r_dly);
    if (we) return 3 + ((a_dly > w_dly) ? a_dly : w_dly) + r_dly;
    return 3 + a_dly + r_dly;
  endfunction

  task automatic idle_inputs();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 0; m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one complete transaction and records what the DUT showed.
  // a_dly: AW (or AR) ready delay; w_dly: W ready delay;
  // r_dly: B/R valid delay; rsp_dly: native response ready delay.
  task automatic run_txn(input logic we, input logic [28:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int a_dly, input int w_dly,
                         input int r_dly, input logic [1:0] resp, input logic [31:0] rd,
                         input int rsp_dly, output obs_t o);
    int  c, acc, w;
    bit  a_seen, w_seen, hs, seen;
    o = '{addr: '0, wdata: '0, wstrb: '0, rdata: '0, err: 1'b0, lat: 0, viol: 0, tmo: 1'b0};

    // Native request
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    c = 0;
    while (req_ready !== 1'b1) begin
      if (c > BOUND) begin o.tmo = 1; do_reset(); return; end
      @(negedge clk); c++;
    end
    acc = cyc;
    @(negedge clk);
    req_valid = 0;
    req_we = 1'($urandom); req_addr = 29'($urandom); req_wdata = $urandom; req_wstrb = 4'($urandom);

    // Address phase
    a_seen = 0; w_seen = !we; c = 0;
    while (!(a_seen && w_seen)) begin
      if (c > BOUND) begin o.tmo = 1; do_reset(); return; end
      if (we) begin
        m_rvalid = 1'($urandom); m_rdata = $urandom;
        m_awready = !a_seen && (c >= a_dly);
        m_wready  = !w_seen && (c >= w_dly);
        if (m_arvalid || m_bready || m_rready || req_ready || rsp_valid) o.viol++;
        if (a_seen == m_awvalid) o.viol++;
        if (w_seen == m_wvalid) o.viol++;
        if (c == 0) begin o.addr = m_awaddr; o.wdata = m_wdata; o.wstrb = m_wstrb; end
        else begin
          if (!a_seen && m_awaddr !== o.addr) o.viol++;
          if (!w_seen && {m_wdata, m_wstrb} !== {o.wdata, o.wstrb}) o.viol++;
        end
        if (m_awvalid && m_awready) a_seen = 1;
        if (m_wvalid && m_wready) w_seen = 1;
      end else begin
        m_bvalid = 1'($urandom); m_bresp = 2'($urandom);
        m_arready = (c >= a_dly);
        if (m_awvalid || m_wvalid || m_bready || m_rready || req_ready || rsp_valid) o.viol++;
        if (!m_arvalid) o.viol++;
        if (c == 0) o.addr = m_araddr;
        else if (m_araddr !== o.addr) o.viol++;
        if (m_arvalid && m_arready) a_seen = 1;
      end
      @(negedge clk); c++;
    end
    m_awready = 0; m_wready = 0; m_arready = 0;

    // Response phase (B or R); stray valids on the other channel must be ignored
    c = 0;
    forever begin
      if (c > BOUND) begin o.tmo = 1; do_reset(); return; end
      if (we) begin
        m_bvalid = (c >= r_dly); m_bresp = resp;
        m_rvalid = 1'($urandom); m_rdata = $urandom;
        if (!m_bready || m_rready) o.viol++;
        hs = m_bvalid;
      end else begin
        m_rvalid = (c >= r_dly); m_rresp = resp; m_rdata = m_rvalid ? rd : $urandom;
        m_bvalid = 1'($urandom);
        if (!m_rready || m_bready) o.viol++;
        hs = m_rvalid;
      end
      if (m_awvalid || m_wvalid || m_arvalid || rsp_valid || req_ready) o.viol++;
      @(negedge clk); c++;
      if (hs) break;
    end
    m_bvalid = 0; m_rvalid = 0;

    // Native response
    c = 0; w = 0; seen = 0;
    forever begin
      if (rsp_valid === 1'b1) begin
        if (!seen) begin
          seen = 1; o.rdata = rsp_rdata; o.err = rsp_err; o.lat = cyc - acc;
        end else if ({rsp_rdata, rsp_err} !== {o.rdata, o.err}) o.viol++;
        if (req_ready || m_awvalid || m_arvalid || m_wvalid || m_bready || m_rready) o.viol++;
        rsp_ready = (c >= rsp_dly);
        if (rsp_ready) begin
          @(negedge clk);
          rsp_ready = 0;
          if (rsp_valid !== 1'b0 || req_ready !== 1'b1) o.viol++;
          break;
        end
        c++;
      end else if (seen) begin
        o.viol++; break;
      end else if (w > BOUND) begin
        o.tmo = 1; do_reset(); return;
      end
      w++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_req_ready: got %b, want 1", req_ready);
    end
    vectors++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_valids: got %b, want 0000000",
               {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err});
    end
    vectors++;
    if ({m_awaddr, m_araddr, m_wdata, m_wstrb, rsp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_payload: got %h %h %h %h %h, want all 0",
               m_awaddr, m_araddr, m_wdata, m_wstrb, rsp_rdata);
    end
  endtask

  task automatic test_min_latency_write();
    obs_t o;
    run_txn(1'b1, 29'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, o);
    vectors++;
    if (o.tmo !== 1'b0 || o.viol !== 0) begin
      miscompares++; $display("FAIL minwr_protocol: tmo=%b viol=%0d, want 0/0", o.tmo, o.viol);
    end
    vectors++;
    if (o.addr !== 32'h80) begin
      miscompares++; $display("FAIL minwr_awaddr: got %h, want 00000080", o.addr);
    end
    vectors++;
    if ({o.wdata, o.wstrb} !== {32'hDEADBEEF, 4'hF}) begin
      miscompares++; $display("FAIL minwr_wdata: got %h/%h, want deadbeef/f", o.wdata, o.wstrb);
    end
    vectors++;
    if (o.lat !== 3) begin
      miscompares++; $display("FAIL minwr_latency: got %0d, want 3", o.lat);
    end
    vectors++;
    if ({o.err, o.rdata} !== 33'h0) begin
      miscompares++; $display("FAIL minwr_rsp: got err=%b rdata=%h, want 0/0", o.err, o.rdata);
    end
  endtask

  task automatic test_w_before_aw();
    obs_t o;
    run_txn(1'b1, 29'h1234, 32'hA5A5_0F0F, 4'h5, 3, 0, 0, 2'b00, 32'h0, 0, o);
    vectors++;
    if (o.tmo !== 1'b0 || o.viol !== 0) begin
      miscompares++; $display("FAIL wfirst_protocol: tmo=%b viol=%0d, want 0/0", o.tmo, o.viol);
    end
    vectors++;
    if (o.lat !== exp_lat(1'b1, 3, 0, 0) || o.err !== 1'b0) begin
      miscompares++;
      $display("FAIL wfirst_rsp: lat=%0d err=%b, want %0d/0", o.lat, o.err, exp_lat(1'b1, 3, 0, 0));
    end
  endtask

  task automatic test_read_slverr();
    obs_t o;
    run_txn(1'b0, 29'h3, 32'h0, 4'h0, 0, 0, 0, 2'b10, 32'h1234_5678, 0, o);
    vectors++;
    if (o.tmo !== 1'b0 || o.viol !== 0) begin
      miscompares++; $display("FAIL rdslv_protocol: tmo=%b viol=%0d, want 0/0", o.tmo, o.viol);
    end
    vectors++;
    if (o.addr !== 32'h18) begin
      miscompares++; $display("FAIL rdslv_araddr: got %h, want 00000018", o.addr);
    end
    vectors++;
    if (o.rdata !== 32'h1234_5678 || o.err !== 1'b1) begin
      miscompares++; $display("FAIL rdslv_rsp: got %h/%b, want 12345678/1", o.rdata, o.err);
    end
    vectors++;
    if (o.lat !== 3) begin
      miscompares++; $display("FAIL rdslv_latency: got %0d, want 3", o.lat);
    end
  endtask

  task automatic test_rsp_stall();
    obs_t o;
    run_txn(1'b0, 29'h0ABC, 32'h0, 4'h0, 1, 0, 1, 2'b00, 32'hCAFE_F00D, 5, o);
    vectors++;
    if (o.tmo !== 1'b0 || o.viol !== 0) begin
      miscompares++; $display("FAIL stall_protocol: tmo=%b viol=%0d, want 0/0", o.tmo, o.viol);
    end
    vectors++;
    if (o.rdata !== 32'hCAFE_F00D || o.err !== 1'b0) begin
      miscompares++; $display("FAIL stall_rsp: got %h/%b, want cafef00d/0", o.rdata, o.err);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic we; logic [28:0] a; logic [31:0] d, rd; logic [3:0] s; logic [1:0] resp;
    int ad, wd, rdl, sd;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); a = 29'($urandom); d = $urandom; s = 4'($urandom);
      ad = $urandom_range(0, 3); wd = $urandom_range(0, 3); rdl = $urandom_range(0, 2);
      resp = 2'($urandom); rd = $urandom; sd = $urandom_range(0, 2);
      run_txn(we, a, d, s, ad, wd, rdl, resp, rd, sd, o);
      vectors++;
      if (o.tmo !== 1'b0 || o.viol !== 0) begin
        miscompares++; $display("FAIL rand%0d_protocol: tmo=%b viol=%0d, want 0/0", i, o.tmo, o.viol);
      end
      vectors++;
      if (o.addr !== exp_addr(a)) begin
        miscompares++; $display("FAIL rand%0d_addr: got %h, want %h", i, o.addr, exp_addr(a));
      end
      if (we) begin
        vectors++;
        if ({o.wdata, o.wstrb} !== {d, s}) begin
          miscompares++; $display("FAIL rand%0d_wdata: got %h/%h, want %h/%h", i, o.wdata, o.wstrb, d, s);
        end
      end
      vectors++;
      if (o.rdata !== (we ? 32'h0 : rd) || o.err !== (resp != 2'b00)) begin
        miscompares++;
        $display("FAIL rand%0d_rsp: got %h/%b, want %h/%b", i, o.rdata, o.err,
                 we ? 32'h0 : rd, resp != 2'b00);
      end
      vectors++;
      if (o.lat !== exp_lat(we, ad, wd, rdl)) begin
        miscompares++; $display("FAIL rand%0d_latency: got %0d, want %0d", i, o.lat, exp_lat(we, ad, wd, rdl));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    obs_t o;
    logic [28:0] a;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 29'h5;
    @(negedge clk);
    req_valid = 0; m_arready = 1;
    @(negedge clk);
    m_arready = 0;
    vectors++;
    if (m_rready !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_rready_entry: got %b, want 1", m_rready);
    end
    #2 arst_n = 1'b0;
    #1;
    vectors++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid} !== 6'b0) begin
      miscompares++;
      $display("FAIL rstmid_valids: got %b, want 000000",
               {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid});
    end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_req_ready: got %b, want 1", req_ready);
    end
    a = 29'($urandom);
    run_txn(1'b0, a, 32'h0, 4'h0, 0, 0, 1, 2'b11, 32'h0BAD_F00D, 0, o);
    vectors++;
    if (o.tmo !== 1'b0 || o.viol !== 0 || o.addr !== exp_addr(a) ||
        o.rdata !== 32'h0BAD_F00D || o.err !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_next_read: tmo=%b viol=%0d addr=%h rdata=%h err=%b, want 0/0/%h/0badf00d/1",
               o.tmo, o.viol, o.addr, o.rdata, o.err, exp_addr(a));
    end
  endtask

`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
  task automatic test_err_cnt();
    obs_t o;
    int model;
    do_reset();
    model = 0;
    for (int i = 0; i < 8; i++) begin
      // Five SLVERR responses, then three OKAY responses.
      run_txn(1'(i % 2), 29'(i), 32'(i), 4'hF, 0, 0, 0, (i < 5) ? 2'b10 : 2'b00, 32'(i), 0, o);
      if (i < 5 && model < 3) model++;
      vectors++;
      if (o.tmo !== 1'b0 || err_cnt !== 2'(model)) begin
        miscompares++; $display("FAIL errcnt%0d: got %0d tmo=%b, want %0d", i, err_cnt, o.tmo, model);
      end
    end
  endtask
`endif

  initial begin
    idle_inputs();
    arst_n = 1'b0;
    test_reset();
    test_min_latency_write();
    test_w_before_aw();
    test_read_slverr();
    test_rsp_stall();
    test_random();
    test_reset_mid_read();
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
